// File: rtl/mp_rr_merge.sv
// N-channel round-robin stream merger: per-channel FIFOs feeding one registered, tagged output.
// Optional per-channel grant counters are enabled by defining MP_RR_STATS_EN.
module mp_rr_merge #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           s_valid,
    output logic [NCH-1:0]           s_ready,
    input  logic [NCH*DW-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DW-1:0]            m_data,
`ifdef MP_RR_STATS_EN
    output logic [NCH*16-1:0]        grant_cnt,
    input  logic                     clr_stats,
`endif
    output logic [$clog2(NCH)-1:0]   m_chan
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CH_ONE   = CW'(1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

    logic [DW-1:0] mem_q    [NCH][DEPTH];
    logic [AW-1:0] rd_ptr_q [NCH];
    logic [AW-1:0] wr_ptr_q [NCH];
    logic [AW:0]   count_q  [NCH];

    logic [CW-1:0] rr_q, rr_d;
    logic          m_valid_q;
    logic [DW-1:0] m_data_q;
    logic [CW-1:0] m_chan_q;

    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           load;
    logic           found;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  idx;

    // Ready depends only on occupancy, so a full FIFO refuses even while popping.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            s_ready[i]  = (count_q[i] != CNT_FULL);
            nonempty[i] = (count_q[i] != '0);
            push[i]     = s_valid[i] && s_ready[i];
        end
    end

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CW'((int'(rr_q) + k) % NCH);
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign load = (!m_valid_q || m_ready) && found;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pop[i] = load && (grant == CW'(i));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (load) begin
            rr_d = (grant == CH_LAST) ? '0 : grant + CH_ONE;
        end
    end

    // Storage carries no reset; occupancy tracking makes stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= s_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_ONE;
                    2'b01:   count_q[i] <= count_q[i] - CNT_ONE;
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_chan_q  <= '0;
        end else begin
            rr_q <= rr_d;
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= mem_q[grant][rd_ptr_q[grant]];
                m_chan_q  <= grant;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;

`ifdef MP_RR_STATS_EN
    logic [15:0] grant_cnt_q [NCH];

    // Clear has priority over a coincident grant; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else if (clr_stats) begin
            for (int i = 0; i < NCH; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else if (m_valid_q && m_ready && (grant_cnt_q[m_chan_q] != 16'hFFFF)) begin
            grant_cnt_q[m_chan_q] <= grant_cnt_q[m_chan_q] + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            grant_cnt[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`else
    // Statistics disabled: no counters or extra ports.
`endif

endmodule

// File: tb/tb_mp_rr_merge.sv
// Directed self-checking bench for mp_rr_merge (NCH=4, DW=32, DEPTH=4).
// Define MP_RR_STATS_EN to also exercise the grant counters.
module tb_mp_rr_merge;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    s_valid;
    logic [NCH-1:0]    s_ready;
    logic [NCH*DW-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_chan;
`ifdef MP_RR_STATS_EN
    logic [NCH*16-1:0] grant_cnt;
    logic              clr_stats;
`endif

    int checks = 0;
    int errors = 0;

    mp_rr_merge #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef MP_RR_STATS_EN
        .grant_cnt (grant_cnt),
        .clr_stats (clr_stats),
`endif
        .m_chan    (m_chan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0] sb[$];
    int          sent;
    int          recv;
    int          cyc;
    logic        prev_stall;
    logic [31:0] held;
    logic        push_now;

    initial begin
        s_valid = '0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef MP_RR_STATS_EN
        clr_stats = 1'b0;
`endif

        // Reset and idle state
        rst = 1'b1;
        step();
        chk("rst_s_ready", 64'(s_ready), 64'hF);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_chan",  64'(m_chan),  64'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_s_ready", 64'(s_ready), 64'hF);
        chk("idle_m_valid", 64'(m_valid), 64'd0);

        // Single word on ch2: visible one cycle after the push edge, then gone
        m_ready = 1'b1;
        s_data[2*DW +: DW] = 32'hA5;
        s_valid = 4'b0100;
        step();
        s_valid = '0;
        chk("single_no_bypass", 64'(m_valid), 64'd0);
        step();
        chk("single_m_valid", 64'(m_valid), 64'd1);
        chk("single_m_data",  64'(m_data),  64'hA5);
        chk("single_m_chan",  64'(m_chan),  64'd2);
        step();
        chk("single_drained", 64'(m_valid), 64'd0);

        // Stalled output, ch1 fills: B0 in output reg, B1..B4 buffered, B5 refused
        m_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            s_data[1*DW +: DW] = 32'hB0 + 32'(n);
            s_valid = 4'b0010;
            chk($sformatf("fill_ready_%0d", n), 64'(s_ready[1]), (n < 5) ? 64'd1 : 64'd0);
            step();
        end
        s_valid = '0;
        chk("fill_full",    64'(s_ready[1]), 64'd0);
        chk("fill_m_valid", 64'(m_valid),    64'd1);
        chk("fill_hold",    64'(m_data),     64'hB0);
        step();
        chk("fill_hold2",   64'(m_data),     64'hB0);
        m_ready = 1'b1;
        for (int n = 1; n < 5; n++) begin
            step();
            chk($sformatf("fill_out_%0d", n), 64'(m_data), 64'hB0 + 64'(n));
            chk($sformatf("fill_ch_%0d", n),  64'(m_chan), 64'd1);
        end
        step();
        chk("fill_no_b5", 64'(m_valid), 64'd0);

        // All channels backlogged: strict rotation, one word per cycle
        do_reset();
        m_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                s_data[ch*DW +: DW] = 32'hC000_0000 + 32'(ch * 256 + n);
            end
            s_valid = 4'hF;
            step();
        end
        s_valid = '0;
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rr_valid_%0d", k), 64'(m_valid), 64'd1);
            chk($sformatf("rr_chan_%0d", k),  64'(m_chan),  64'(k % 4));
            chk($sformatf("rr_data_%0d", k),  64'(m_data),
                64'(32'hC000_0000 + 32'((k % 4) * 256 + k / 4)));
            step();
        end
        chk("rr_drained", 64'(m_valid), 64'd0);

        // Toggling m_ready with a scoreboard on ch3
        sent = 0;
        recv = 0;
        cyc = 0;
        prev_stall = 1'b0;
        held = '0;
        while (recv < 8 && cyc < 60) begin
            if (prev_stall) begin
                chk("stall_hold", 64'(m_data), 64'(held));
            end
            m_ready = cyc[0];
            s_valid = (sent < 8) ? 4'b1000 : 4'b0000;
            s_data[3*DW +: DW] = 32'hD00 + 32'(sent);
            push_now = s_valid[3] && s_ready[3];
            if (m_valid && m_ready) begin
                chk("sb_extra_word", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    chk("sb_data", 64'(m_data), 64'(sb[0]));
                    void'(sb.pop_front());
                end
                recv++;
            end
            if (push_now) begin
                sb.push_back(32'hD00 + 32'(sent));
            end
            prev_stall = m_valid && !m_ready;
            held = m_data;
            step();
            if (push_now) begin
                sent++;
            end
            cyc++;
        end
        s_valid = '0;
        chk("sb_recv_count", 64'(recv),      64'd8);
        chk("sb_empty",      64'(sb.size()), 64'd0);

        // Reset asserted mid-burst
        m_ready = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            s_data[ch*DW +: DW] = 32'hE0 + 32'(ch);
        end
        s_valid = 4'hF;
        step();
        step();
        chk("burst_active", 64'(m_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data",  64'(m_data),  64'd0);
        chk("mid_rst_m_chan",  64'(m_chan),  64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'hF);
        s_valid = '0;
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("no_stale_%0d", n), 64'(m_valid), 64'd0);
        end

`ifdef MP_RR_STATS_EN
        chk("stats_rst", 64'(grant_cnt), 64'd0);
        s_data[0*DW +: DW] = 32'hF00;
        s_valid = 4'b0001;
        m_ready = 1'b1;
        repeat (70010) step();
        chk("stats_sat_ch0", 64'(grant_cnt[15:0]),  64'hFFFF);
        chk("stats_ch1",     64'(grant_cnt[31:16]), 64'd0);
        chk("stats_grant_live", 64'(m_valid), 64'd1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("stats_clr_wins", 64'(grant_cnt), 64'd0);
        step();
        chk("stats_after_clr", 64'(grant_cnt[15:0]), 64'd1);
        s_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
